// File: rtl/systolic_ctrl.sv
// systolic_ctrl: holds A/B tiles, feeds them skewed into a DIM x DIM
// output-stationary array, drains, captures C and returns it row by row.
module systolic_ctrl #(
   parameter int DATA_W    = 16,
   parameter int DIM       = 4,
   parameter int K_MAX     = 8,
   parameter int DRAIN_CYC = 2 * DIM
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [$clog2(K_MAX+1)-1:0]       cfg_k,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   input  logic                             a_wr_en,
   input  logic [$clog2(DIM)-1:0]           a_wr_row,
   input  logic [$clog2(K_MAX)-1:0]         a_wr_k,
   input  logic [DATA_W-1:0]                a_wr_data,
   input  logic                             b_wr_en,
   input  logic [$clog2(DIM)-1:0]           b_wr_col,
   input  logic [$clog2(K_MAX)-1:0]         b_wr_k,
   input  logic [DATA_W-1:0]                b_wr_data,
   output logic                             wr_rejected,
   output logic [DIM*DATA_W-1:0]            arr_a,
   output logic [DIM*DATA_W-1:0]            arr_b,
   output logic                             arr_valid,
   input  logic [DIM*DIM*2*DATA_W-1:0]      arr_c,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [$clog2(DIM)-1:0]           res_row,
   output logic [DIM*2*DATA_W-1:0]          res_data
);

   localparam int RW    = $clog2(DIM);
   localparam int KW    = $clog2(K_MAX);
   localparam int CW    = $clog2(K_MAX+1);
   localparam int TW    = $clog2(K_MAX+DIM);
   localparam int DCW   = $clog2(DRAIN_CYC+1);
   localparam int DW2   = 2 * DATA_W;
   localparam int ROW_W = DIM * DW2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t                  r_state;
   logic [DATA_W-1:0]       r_a [DIM][K_MAX];
   logic [DATA_W-1:0]       r_b [K_MAX][DIM];
   logic [CW-1:0]           r_k;
   logic [TW-1:0]           r_t;
   logic [DCW-1:0]          r_dc;
   logic [RW-1:0]           r_row;
   logic [DIM*ROW_W-1:0]    r_res;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_rej;
   logic                    r_arr_valid;
   logic                    r_res_valid;
   logic [DIM*DATA_W-1:0]   r_arr_a;
   logic [DIM*DATA_W-1:0]   r_arr_b;
   logic [ROW_W-1:0]        r_res_data;

   logic [DIM*DATA_W-1:0]   w_feed_a;
   logic [DIM*DATA_W-1:0]   w_feed_b;
   logic [CW-1:0]           w_k;
   logic [RW-1:0]           w_row_nx;
   logic                    w_idle;
   logic                    w_last_t;

   assign w_idle   = (r_state == S_IDLE);
   assign w_k      = (cfg_k > CW'(K_MAX)) ? CW'(K_MAX) : cfg_k;
   assign w_row_nx = r_row + 1'b1;
   assign w_last_t = (int'(r_t) == int'(r_k) + DIM - 2);

   // Operand for row i / column j at skew step t is element t-i / t-j.
   always_comb begin
      w_feed_a = '0;
      w_feed_b = '0;
      for (int i = 0; i < DIM; i++) begin
         if (int'(r_t) >= i && int'(r_t) - i < int'(r_k)) begin
            w_feed_a[i*DATA_W +: DATA_W] = r_a[i][KW'(int'(r_t) - i)];
            w_feed_b[i*DATA_W +: DATA_W] = r_b[KW'(int'(r_t) - i)][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_t         <= '0;
         r_dc        <= '0;
         r_row       <= '0;
         r_res       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rej       <= 1'b0;
         r_arr_valid <= 1'b0;
         r_res_valid <= 1'b0;
         r_arr_a     <= '0;
         r_arr_b     <= '0;
         r_res_data  <= '0;
      end else begin
         r_done <= 1'b0;
         r_rej  <= (a_wr_en || b_wr_en) && !w_idle;
         // Tile storage has no reset so contents persist across resets.
         if (w_idle && a_wr_en && int'(a_wr_k) < K_MAX)
            r_a[a_wr_row][a_wr_k] <= a_wr_data;
         if (w_idle && b_wr_en && int'(b_wr_k) < K_MAX)
            r_b[b_wr_k][b_wr_col] <= b_wr_data;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_k    <= w_k;
                  r_busy <= 1'b1;
                  if (w_k == '0) begin
                     r_state     <= S_OUT;
                     r_res       <= '0;
                     r_res_data  <= '0;
                     r_row       <= '0;
                     r_res_valid <= 1'b1;
                  end else begin
                     r_state <= S_FEED;
                     r_t     <= '0;
                  end
               end
            end
            S_FEED: begin
               r_arr_valid <= 1'b1;
               r_arr_a     <= w_feed_a;
               r_arr_b     <= w_feed_b;
               if (w_last_t) begin
                  r_state <= S_DRAIN;
                  r_dc    <= '0;
               end else begin
                  r_t <= r_t + 1'b1;
               end
            end
            S_DRAIN: begin
               r_arr_valid <= 1'b0;
               r_arr_a     <= '0;
               r_arr_b     <= '0;
               if (r_dc == DCW'(DRAIN_CYC)) begin
                  r_state     <= S_OUT;
                  r_res       <= arr_c;
                  r_res_data  <= arr_c[0 +: ROW_W];
                  r_row       <= '0;
                  r_res_valid <= 1'b1;
               end else begin
                  r_dc <= r_dc + 1'b1;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  if (r_row == RW'(DIM-1)) begin
                     r_state     <= S_IDLE;
                     r_res_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                  end else begin
                     r_row      <= w_row_nx;
                     r_res_data <= r_res[int'(w_row_nx)*ROW_W +: ROW_W];
                  end
               end
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign wr_rejected = r_rej;
   assign arr_a       = r_arr_a;
   assign arr_b       = r_arr_b;
   assign arr_valid   = r_arr_valid;
   assign res_valid   = r_res_valid;
   assign res_row     = r_row;
   assign res_data    = r_res_data;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: random and directed runs of systolic_ctrl against a
// tile/array model; compares every output on every falling edge.
module tb_systolic_ctrl;

   localparam int DW  = 16;
   localparam int DIM = 4;
   localparam int KM  = 8;
   localparam int DC  = 2 * DIM;
   localparam int RW  = $clog2(DIM);
   localparam int KW  = $clog2(KM);
   localparam int CW  = $clog2(KM+1);
   localparam int ROW = DIM * 2 * DW;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [CW-1:0]         cfg_k;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  a_wr_en;
   logic [RW-1:0]         a_wr_row;
   logic [KW-1:0]         a_wr_k;
   logic [DW-1:0]         a_wr_data;
   logic                  b_wr_en;
   logic [RW-1:0]         b_wr_col;
   logic [KW-1:0]         b_wr_k;
   logic [DW-1:0]         b_wr_data;
   logic                  wr_rejected;
   logic [DIM*DW-1:0]     arr_a;
   logic [DIM*DW-1:0]     arr_b;
   logic                  arr_valid;
   logic [DIM*ROW-1:0]    arr_c;
   logic                  res_valid;
   logic                  res_ready;
   logic [RW-1:0]         res_row;
   logic [ROW-1:0]        res_data;

   systolic_ctrl #(.DATA_W(DW), .DIM(DIM), .K_MAX(KM), .DRAIN_CYC(DC)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .start(start),
      .busy(busy), .done(done),
      .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_k(a_wr_k),
      .a_wr_data(a_wr_data),
      .b_wr_en(b_wr_en), .b_wr_col(b_wr_col), .b_wr_k(b_wr_k),
      .b_wr_data(b_wr_data),
      .wr_rejected(wr_rejected), .arr_a(arr_a), .arr_b(arr_b),
      .arr_valid(arr_valid), .arr_c(arr_c),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_row(res_row), .res_data(res_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [511:0] got, logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Array model: PE(i,j) multiplies row i's stream delayed j cycles
   // with column j's stream delayed i cycles.
   logic [DIM*DW-1:0] ha [32];
   logic [DIM*DW-1:0] hb [32];
   int hc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hc = 0;
      end else if (arr_valid) begin
         if (hc < 32) begin
            ha[hc] = arr_a;
            hb[hc] = arr_b;
            hc++;
         end
      end else if (hc > 0) begin
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               longint acc;
               acc = 0;
               for (int tau = 0; tau < hc + 2*DIM; tau++) begin
                  int ia, ib;
                  ia = tau - j;
                  ib = tau - i;
                  if (ia >= 0 && ia < hc && ib >= 0 && ib < hc)
                     acc += longint'($signed(ha[ia][i*DW +: DW])) *
                            longint'($signed(hb[ib][j*DW +: DW]));
               end
               arr_c[(i*DIM+j)*2*DW +: 2*DW] = acc[2*DW-1:0];
            end
         hc = 0;
      end else if (!busy) begin
         for (int w = 0; w < DIM*DIM; w++)
            arr_c[w*32 +: 32] = $urandom;
      end
   end

   // Tile and sequencing model.
   logic signed [DW-1:0] ma [DIM][KM];
   logic signed [DW-1:0] mb [KM][DIM];
   longint gold [DIM][DIM];
   bit run_active = 0;
   bit exp_done = 0;
   bit exp_rej = 0;
   int n, rk, el, first_n, exp_row;
   int run_cnt = 0;

   function automatic logic [DIM*DW-1:0] feed_a(int t);
      logic [DIM*DW-1:0] v;
      v = '0;
      for (int i = 0; i < DIM; i++)
         if (t - i >= 0 && t - i < rk) v[i*DW +: DW] = ma[i][t-i];
      return v;
   endfunction

   function automatic logic [DIM*DW-1:0] feed_b(int t);
      logic [DIM*DW-1:0] v;
      v = '0;
      for (int j = 0; j < DIM; j++)
         if (t - j >= 0 && t - j < rk) v[j*DW +: DW] = mb[t-j][j];
      return v;
   endfunction

   function automatic logic [ROW-1:0] gold_row(int r);
      logic [ROW-1:0] v;
      for (int j = 0; j < DIM; j++) v[j*2*DW +: 2*DW] = gold[r][j][2*DW-1:0];
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", 512'(busy), 512'(0));
         chk("rst_done", 512'(done), 512'(0));
         chk("rst_rej", 512'(wr_rejected), 512'(0));
         chk("rst_av", 512'(arr_valid), 512'(0));
         chk("rst_rv", 512'(res_valid), 512'(0));
         chk("rst_arr", 512'({arr_a, arr_b}), 512'(0));
         chk("rst_res", 512'({res_row, res_data}), 512'(0));
         run_active = 0;
         exp_done = 0;
         exp_rej = 0;
      end else begin
         chk("wr_rejected", 512'(wr_rejected), 512'(exp_rej));
         if (exp_done) begin
            chk("done_pulse", 512'(done), 512'(1));
            chk("done_busy", 512'(busy), 512'(0));
            chk("done_rv", 512'(res_valid), 512'(0));
            exp_done = 0;
            run_active = 0;
         end else if (run_active) begin
            n++;
            chk("run_busy", 512'(busy), 512'(1));
            chk("run_done", 512'(done), 512'(0));
            chk("arr_valid", 512'(arr_valid), 512'(rk > 0 && n >= 1 && n <= el));
            chk("arr_a", 512'(arr_a), 512'(feed_a(n - 1)));
            chk("arr_b", 512'(arr_b), 512'(feed_b(n - 1)));
            if (run_cnt == 1 && n == 1)
               chk("lit_t0_a", 512'(arr_a), 512'(64'h0000_0000_0000_0001));
            if (run_cnt == 1 && n == 4)
               chk("lit_t3_a", 512'(arr_a), 512'(64'h001F_0016_000D_0004));
            if (run_cnt == 1 && n == 7)
               chk("lit_t6", 512'({arr_a[63:48], arr_b[63:48]}), 512'(32'h0022_0007));
            if (n < first_n) begin
               chk("rv_early", 512'(res_valid), 512'(0));
            end else begin
               chk("res_valid", 512'(res_valid), 512'(1));
               chk("res_row", 512'(res_row), 512'(exp_row));
               chk("res_data", 512'(res_data), 512'(gold_row(exp_row)));
               if (run_cnt == 1 && n == first_n) begin
                  chk("lit_lat", 512'(n), 512'(16));
                  chk("lit_c00", 512'(res_data[31:0]), 512'(30));
               end
               if (run_cnt == 1 && exp_row == 3)
                  chk("lit_c33", 512'(res_data[127:96]), 512'(720));
               if (res_ready) begin
                  if (exp_row == DIM - 1) exp_done = 1;
                  else exp_row++;
               end
            end
         end else begin
            chk("idle_busy", 512'(busy), 512'(0));
            chk("idle_done", 512'(done), 512'(0));
            chk("idle_av", 512'(arr_valid), 512'(0));
            chk("idle_rv", 512'(res_valid), 512'(0));
         end
         exp_rej = run_active && (a_wr_en || b_wr_en);
         if (!run_active) begin
            if (a_wr_en && int'(a_wr_k) < KM) ma[a_wr_row][a_wr_k] = a_wr_data;
            if (b_wr_en && int'(b_wr_k) < KM) mb[b_wr_k][b_wr_col] = b_wr_data;
            if (start) begin
               run_active = 1;
               n = -1;
               rk = (int'(cfg_k) > KM) ? KM : int'(cfg_k);
               el = rk + DIM - 1;
               first_n = (rk == 0) ? 0 : el + DC + 1;
               exp_row = 0;
               run_cnt++;
               for (int i = 0; i < DIM; i++)
                  for (int j = 0; j < DIM; j++) begin
                     gold[i][j] = 0;
                     for (int kk = 0; kk < rk; kk++)
                        gold[i][j] += longint'(ma[i][kk]) * longint'(mb[kk][j]);
                  end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pattern();
      for (int i = 0; i < DIM; i++)
         for (int kk = 0; kk < KM; kk++) begin
            a_wr_en = 1; a_wr_row = RW'(i); a_wr_k = KW'(kk);
            a_wr_data = DW'(10*i + kk + 1);
            b_wr_en = 1; b_wr_col = RW'(i); b_wr_k = KW'(kk);
            b_wr_data = DW'(kk + i + 1);
            tick();
         end
      a_wr_en = 0;
      b_wr_en = 0;
   endtask

   // mode 0: ready high, 1: stall row 1, 2: misuse, 3: random ready/writes
   task automatic run(int k, int mode);
      bit seen;
      int stall;
      seen = 0;
      stall = 0;
      cfg_k = CW'(k);
      start = 1;
      tick();
      start = 0;
      for (int c = 0; c < 400 && !seen; c++) begin
         case (mode)
            1: begin
               if (res_valid && res_row == 1 && stall < 5) begin
                  res_ready = 0;
                  stall++;
               end else res_ready = 1;
            end
            2: begin
               res_ready = 1;
               start = (c == 2);
               if (c == 2) cfg_k = CW'(2);
               a_wr_en = (c == 10);
               a_wr_row = 1; a_wr_k = 1; a_wr_data = 777;
            end
            3: begin
               res_ready = 1'($urandom);
               a_wr_en = ($urandom % 8 == 0);
               a_wr_row = RW'($urandom); a_wr_k = KW'($urandom);
               a_wr_data = DW'($urandom);
               b_wr_en = ($urandom % 8 == 0);
               b_wr_col = RW'($urandom); b_wr_k = KW'($urandom);
               b_wr_data = DW'($urandom);
            end
            default: res_ready = 1;
         endcase
         tick();
         if (done) seen = 1;
      end
      start = 0;
      a_wr_en = 0;
      b_wr_en = 0;
      if (!seen) begin
         $display("FAIL run_timeout k=%0d mode=%0d got=no done exp=done", k, mode);
         $fatal(1);
      end
   endtask

   initial begin
      rst_n = 0; start = 0; cfg_k = '0; res_ready = 0;
      a_wr_en = 0; a_wr_row = '0; a_wr_k = '0; a_wr_data = '0;
      b_wr_en = 0; b_wr_col = '0; b_wr_k = '0; b_wr_data = '0;
      repeat (3) tick();
      rst_n = 1;
      tick();
      load_pattern();
      rst_n = 0;
      a_wr_en = 1; a_wr_row = 0; a_wr_k = 5; a_wr_data = 999;
      b_wr_en = 1; b_wr_col = 0; b_wr_k = 5; b_wr_data = 999;
      repeat (2) tick();
      a_wr_en = 0;
      b_wr_en = 0;
      rst_n = 1;
      tick();
      run(4, 0);
      run(4, 1);
      run(4, 2);
      run(4, 0);
      run(0, 3);
      run(12, 3);
      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 12; w++) begin
            a_wr_en = 1'($urandom); a_wr_row = RW'($urandom);
            a_wr_k = KW'($urandom); a_wr_data = DW'($urandom);
            b_wr_en = 1'($urandom); b_wr_col = RW'($urandom);
            b_wr_k = KW'($urandom); b_wr_data = DW'($urandom);
            tick();
         end
         a_wr_en = 0;
         b_wr_en = 0;
         run(int'($urandom_range(0, 15)), 3);
      end
      load_pattern();
      res_ready = 1;
      cfg_k = CW'(4);
      start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();
      run(4, 0);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
